// File: rtl/matmul_seq_ctrl_pkg.sv
// Shared state encoding and width/address helpers for the matmul sequencer.
// The address-width formula is shared with the MAC datapath.
package matmul_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Number of bits needed to hold v; zero still takes one bit.
    function automatic int log2(input int v);
        int b;
        b = 0;
        for (int t = v; t > 0; t = t >> 1) begin
            b++;
        end
        return (b == 0) ? 1 : b;
    endfunction

    function automatic int addr_width(input int n);
        return log2(n * n);
    endfunction

    function automatic int flat_addr(input int n, input int row, input int col);
        return n * row + col;
    endfunction

endpackage

// File: rtl/matmul_seq_ctrl_idx_counter.sv
// Nested i/j/k loop counter with explicit compare-based wraps.
// Flags mark the last k of an element and the last issue of the matrix.
module matmul_seq_ctrl_idx_counter
    import matmul_seq_ctrl_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = log2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          step,
    input  logic          clr,
    output logic [IW-1:0] i,
    output logic [IW-1:0] j,
    output logic [IW-1:0] k,
    output logic          last_k,
    output logic          last_all
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    logic [IW-1:0] r_i;
    logic [IW-1:0] r_j;
    logic [IW-1:0] r_k;
    logic          w_last_i;
    logic          w_last_j;

    assign w_last_i = (r_i == LAST);
    assign w_last_j = (r_j == LAST);
    assign last_k   = (r_k == LAST);
    assign last_all = last_k && w_last_j && w_last_i;

    assign i = r_i;
    assign j = r_j;
    assign k = r_k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (clr) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (step) begin
            if (last_k) begin
                r_k <= '0;
                if (w_last_j) begin
                    r_j <= '0;
                    r_i <= w_last_i ? '0 : r_i + 1'b1;
                end else begin
                    r_j <= r_j + 1'b1;
                end
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Sequencer for a shared single-MAC N x N matrix multiplier.
// Counters hold the next issue; the write flag rides one stage behind it.
module matmul_seq_ctrl
    import matmul_seq_ctrl_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = log2(N),
    parameter int AW = addr_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] x_addr,
    output logic [AW-1:0] y_addr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          o_we,
    output logic [AW-1:0] o_addr
);

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic          r_mac_en;
    logic          r_mac_clr;
    logic          r_o_we;
    logic          r_wr_pend;
    logic          r_last;
    logic [AW-1:0] r_x_addr;
    logic [AW-1:0] r_y_addr;
    logic [AW-1:0] r_o_addr;
    logic [AW-1:0] r_wr_addr;

    logic [IW-1:0] w_i;
    logic [IW-1:0] w_j;
    logic [IW-1:0] w_k;
    logic          w_last_k;
    logic          w_last_all;
    logic          w_active;
    logic          w_run_end;
    logic          w_issue;
    logic          w_clr;
    logic [AW-1:0] w_x_addr;
    logic [AW-1:0] w_y_addr;
    logic [AW-1:0] w_e_addr;

    matmul_seq_ctrl_idx_counter #(
        .N  (N),
        .IW (IW)
    ) u_idx (
        .clk      (clk),
        .rst_n    (rst_n),
        .step     (w_issue),
        .clr      (w_clr),
        .i        (w_i),
        .j        (w_j),
        .k        (w_k),
        .last_k   (w_last_k),
        .last_all (w_last_all)
    );

    assign w_active  = (r_state == S_RUN) || (r_state == S_DRAIN);
    // The final issue is on the bus this cycle; nothing more to issue.
    assign w_run_end = r_mac_en && r_last;
    assign w_clr     = w_active && abort;
    assign w_issue   = !hold &&
                       (((r_state == S_IDLE) && start) ||
                        ((r_state == S_RUN) && !abort && !w_run_end));

    assign w_x_addr = AW'(flat_addr(N, int'(w_i), int'(w_k)));
    assign w_y_addr = AW'(flat_addr(N, int'(w_k), int'(w_j)));
    assign w_e_addr = AW'(flat_addr(N, int'(w_i), int'(w_j)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mac_en  <= 1'b0;
            r_mac_clr <= 1'b0;
            r_o_we    <= 1'b0;
            r_wr_pend <= 1'b0;
            r_last    <= 1'b0;
            r_x_addr  <= '0;
            r_y_addr  <= '0;
            r_o_addr  <= '0;
            r_wr_addr <= '0;
        end else begin
            r_mac_en  <= w_issue;
            r_mac_clr <= w_issue && (w_k == '0);
            r_x_addr  <= w_issue ? w_x_addr : '0;
            r_y_addr  <= w_issue ? w_y_addr : '0;
            r_wr_pend <= w_issue && w_last_k;
            r_wr_addr <= (w_issue && w_last_k) ? w_e_addr : '0;
            r_last    <= w_issue && w_last_all;
            // A pending write fires through hold but not through abort.
            r_o_we    <= r_wr_pend && !w_clr;
            r_o_addr  <= (r_wr_pend && !w_clr) ? r_wr_addr : '0;
            r_done    <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_run_end) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_busy <= 1'b0;
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign x_addr  = r_x_addr;
    assign y_addr  = r_y_addr;
    assign mac_en  = r_mac_en;
    assign mac_clr = r_mac_clr;
    assign o_we    = r_o_we;
    assign o_addr  = r_o_addr;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: N=3, N=1 and N=4 instances, each paired
// with a behavioural 32-bit MAC and x/y/o arrays.
`timescale 1ns/1ps
module tb_matmul_seq_ctrl;

    localparam int A3 = 4;
    localparam int A1 = 1;
    localparam int A4 = 5;
    localparam logic [31:0] SENT = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic          s3_start = 1'b0;
    logic          s3_abort = 1'b0;
    logic          s3_hold  = 1'b0;
    logic          s1_start = 1'b0;
    logic          s4_start = 1'b0;
    logic          tie0     = 1'b0;

    logic          busy3, done3, en3, clr3, we3;
    logic [A3-1:0] xa3, ya3, oa3;
    logic          busy1, done1, en1, clr1, we1;
    logic [A1-1:0] xa1, ya1, oa1;
    logic          busy4, done4, en4, clr4, we4;
    logic [A4-1:0] xa4, ya4, oa4;

    logic [31:0] x3 [16];
    logic [31:0] y3 [16];
    logic [31:0] o3 [16];
    logic [31:0] acc3;
    logic [31:0] x1 [2];
    logic [31:0] y1 [2];
    logic [31:0] o1 [2];
    logic [31:0] acc1;
    logic [31:0] x4 [32];
    logic [31:0] y4 [32];
    logic [31:0] o4 [32];
    logic [31:0] acc4;

    matmul_seq_ctrl #(.N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(s3_start), .abort(s3_abort),
        .hold(s3_hold), .busy(busy3), .done(done3), .x_addr(xa3),
        .y_addr(ya3), .mac_en(en3), .mac_clr(clr3), .o_we(we3),
        .o_addr(oa3)
    );

    matmul_seq_ctrl #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .abort(tie0),
        .hold(tie0), .busy(busy1), .done(done1), .x_addr(xa1),
        .y_addr(ya1), .mac_en(en1), .mac_clr(clr1), .o_we(we1),
        .o_addr(oa1)
    );

    matmul_seq_ctrl #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start), .abort(tie0),
        .hold(tie0), .busy(busy4), .done(done4), .x_addr(xa4),
        .y_addr(ya4), .mac_en(en4), .mac_clr(clr4), .o_we(we4),
        .o_addr(oa4)
    );

    // Behavioural MACs: registered accumulator, write samples the old value
    always @(posedge clk) begin
        if (en3) acc3 <= (clr3 ? 32'd0 : acc3) + x3[xa3] * y3[ya3];
        if (we3) o3[oa3] <= acc3;
        if (en1) acc1 <= (clr1 ? 32'd0 : acc1) + x1[xa1] * y1[ya1];
        if (we1) o1[oa1] <= acc1;
        if (en4) acc4 <= (clr4 ? 32'd0 : acc4) + x4[xa4] * y4[ya4];
        if (we4) o4[oa4] <= acc4;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input int busy, input int done,
                                       input int en, input int clr,
                                       input int we, input int xa,
                                       input int ya, input int oa);
        return {35'd0, 1'(busy), 1'(done), 1'(en), 1'(clr), 1'(we),
                8'(xa), 8'(ya), 8'(oa)};
    endfunction

    function automatic logic [63:0] obs3();
        return pk(int'(busy3), int'(done3), int'(en3), int'(clr3),
                  int'(we3), int'(xa3), int'(ya3), int'(oa3));
    endfunction

    function automatic logic [63:0] obs1();
        return pk(int'(busy1), int'(done1), int'(en1), int'(clr1),
                  int'(we1), int'(xa1), int'(ya1), int'(oa1));
    endfunction

    function automatic logic [63:0] obs4();
        return pk(int'(busy4), int'(done4), int'(en4), int'(clr4),
                  int'(we4), int'(xa4), int'(ya4), int'(oa4));
    endfunction

    // Expected outputs in cycle c of a hold-free run (start in cycle 0)
    function automatic logic [63:0] exp_plain(input int n, input int c);
        int total, is, ws, i, j, k, en, we, bz, dn;
        total = n * n * n;
        is = c - 1;
        ws = c - 2;
        en = (c >= 1 && c <= total) ? 1 : 0;
        i = is / (n * n);
        j = (is / n) % n;
        k = is % n;
        we = (c >= 2 && c <= total + 1 && (ws % n) == n - 1) ? 1 : 0;
        bz = (c >= 1 && c <= total + 1) ? 1 : 0;
        dn = (c == total + 2) ? 1 : 0;
        return pk(bz, dn, en, (en == 1 && k == 0) ? 1 : 0, we,
                  (en == 1) ? n * i + k : 0, (en == 1) ? n * k + j : 0,
                  (we == 1) ? ws / n : 0);
    endfunction

    // N=3 run with optional hold window, stray start and abort
    task automatic run3(input int hold_at, input int hold_len,
                        input int start_at, input int abort_at);
        int n, c, drain_c, done_c, end_c, wpend, nwp;
        int i, j, k, en, hprev, ab;
        n = 0;
        hprev = 0;
        wpend = -1;
        ab = 0;
        drain_c = 1000;
        done_c = 1000;
        end_c = 1000;
        s3_start = 1'b1;
        @(negedge clk);
        s3_start = 1'b0;
        c = 1;
        while (1) begin
            en = (ab == 0 && hprev == 0 && n < 27) ? 1 : 0;
            i = n / 9;
            j = (n / 3) % 3;
            k = n % 3;
            check($sformatf("n3 cyc%0d", c), obs3(),
                  pk((ab == 0 && c <= drain_c) ? 1 : 0,
                     (ab == 0 && c == done_c) ? 1 : 0,
                     en, (en == 1 && k == 0) ? 1 : 0,
                     (wpend >= 0) ? 1 : 0,
                     (en == 1) ? 3 * i + k : 0,
                     (en == 1) ? 3 * k + j : 0,
                     (wpend >= 0) ? wpend : 0));
            nwp = -1;
            if (en == 1) begin
                if (k == 2) nwp = 3 * i + j;
                if (n == 26) begin
                    drain_c = c + 1;
                    done_c = c + 2;
                    end_c = c + 3;
                end
                n++;
            end
            s3_hold = (c >= hold_at) && (c < hold_at + hold_len);
            s3_abort = (c == abort_at);
            s3_start = (c == start_at);
            if (c == abort_at) begin
                ab = 1;
                nwp = -1;
                end_c = c + 3;
            end
            wpend = nwp;
            hprev = s3_hold ? 1 : 0;
            if (c >= end_c) break;
            if (c >= 120) begin
                check("n3 timeout", 64'(c), 64'(end_c));
                break;
            end
            @(negedge clk);
            c++;
        end
        s3_hold = 1'b0;
        s3_abort = 1'b0;
        s3_start = 1'b0;
    endtask

    task automatic fill3(input int mode);
        for (int e = 0; e < 16; e++) begin
            o3[e] = SENT;
            case (mode)
                0: begin
                    x3[e] = 32'(e + 1);
                    y3[e] = (e == 0 || e == 4 || e == 8) ? 32'd1 : 32'd0;
                end
                1: begin
                    x3[e] = 32'd2;
                    y3[e] = 32'd2;
                end
                2: begin
                    x3[e] = 32'hFFFF_FFFF;
                    y3[e] = 32'd2;
                end
                default: begin
                    x3[e] = $urandom();
                    y3[e] = $urandom();
                end
            endcase
        end
    endtask

    task automatic res3(input string tag, input int upto);
        logic [31:0] s;
        for (int e = 0; e < 9; e++) begin
            s = '0;
            for (int k = 0; k < 3; k++) begin
                s = s + x3[3 * (e / 3) + k] * y3[3 * k + e % 3];
            end
            check($sformatf("%s o[%0d]", tag, e), 64'(o3[e]),
                  64'((e < upto) ? s : SENT));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        int ha, hl;
        repeat (2) @(negedge clk);
        check("reset n3", obs3(), 64'd0);
        check("reset n1", obs1(), 64'd0);
        check("reset n4", obs4(), 64'd0);
        rst_n = 1'b1;

        fill3(0);
        run3(999, 0, 999, 999);
        res3("ident", 9);
        check("ident o[8]", 64'(o3[8]), 64'd9);

        fill3(1);
        run3(999, 0, 999, 999);
        res3("twos", 9);
        check("twos o[0]", 64'(o3[0]), 64'd12);

        fill3(2);
        run3(999, 0, 999, 999);
        res3("wrap", 9);
        check("wrap o[4]", 64'(o3[4]), 64'hFFFF_FFFA);

        fill3(0);
        run3(13, 3, 999, 999);
        res3("hold", 9);

        fill3(3);
        run3(999, 0, 10, 29);
        res3("stray", 9);
        fill3(3);
        run3(999, 0, 999, 999);
        res3("back2back", 9);

        ha = int'($urandom_range(2, 24));
        hl = int'($urandom_range(1, 4));
        fill3(3);
        run3(ha, hl, 999, 999);
        res3("rhold", 9);

        fill3(0);
        run3(999, 0, 999, 19);
        res3("abort", 6);
        fill3(1);
        run3(999, 0, 999, 999);
        res3("post_abort", 9);

        s3_start = 1'b1;
        @(negedge clk);
        s3_start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async reset n3", obs3(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        fill3(3);
        run3(999, 0, 999, 999);
        res3("post_reset", 9);

        x1[0] = $urandom();
        y1[0] = $urandom();
        o1[0] = SENT;
        s1_start = 1'b1;
        @(negedge clk);
        s1_start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("n1 cyc%0d", c), obs1(), exp_plain(1, c));
            @(negedge clk);
        end
        s = x1[0] * y1[0];
        check("n1 o[0]", 64'(o1[0]), 64'(s));

        for (int e = 0; e < 16; e++) begin
            x4[e] = $urandom();
            y4[e] = $urandom();
            o4[e] = SENT;
        end
        s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        for (int c = 1; c <= 67; c++) begin
            check($sformatf("n4 cyc%0d", c), obs4(), exp_plain(4, c));
            @(negedge clk);
        end
        for (int e = 0; e < 16; e++) begin
            s = '0;
            for (int k = 0; k < 4; k++) begin
                s = s + x4[4 * (e / 4) + k] * y4[4 * k + e % 4];
            end
            check($sformatf("n4 o[%0d]", e), 64'(o4[e]), 64'(s));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
